// File: rtl/tinker_mem_ctrl.sv
// tinker_mem_ctrl: fetch/data memory controller, round-robin arbiter, programmable latency.
// Define TINKER_MEM_BOUNDS_EN to flag out-of-range accesses instead of wrapping.
module tinker_mem_ctrl #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int IF_W      = 32,
    parameter int MEM_BYTES = 524288,
    parameter int LATENCY   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [IF_W-1:0]     if_rdata,
    input  logic                d_valid,
    output logic                d_ready,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                busy,
    output logic                err
);
    localparam int MA = $clog2(MEM_BYTES);
    localparam int DB = DATA_W / 8;
    localparam int FB = IF_W / 8;
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic CH_F = 1'b0;
    localparam logic CH_D = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [7:0] mem [MEM_BYTES];

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic              chan_q, chan_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DB-1:0]     be_q, be_d;
    logic [IF_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              gnt_d, gnt_f, resp, oob;
    logic [DATA_W-1:0] rd_data;
    logic [IF_W-1:0]   rd_if;

    function automatic logic [MA-1:0] bidx(input logic [ADDR_W-1:0] a, input int k);
        logic [MA-1:0] b;
        b = a[MA-1:0];
        return b + MA'(k);
    endfunction

    // Grant the channel that did not win last time when both request.
    always_comb begin
        gnt_d = 1'b0;
        gnt_f = 1'b0;
        if (reset && state_q == S_IDLE) begin
            gnt_d = d_valid && (!if_valid || rr_q == CH_F);
            gnt_f = if_valid && !gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (gnt_d || gnt_f) state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == CW'(1)) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        chan_d  = chan_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        if (gnt_d || gnt_f) begin
            cnt_d   = CW'(LATENCY - 1);
            rr_d    = gnt_d;
            chan_d  = gnt_d;
            we_d    = gnt_d & d_we;
            addr_d  = gnt_d ? d_addr : if_addr;
            wdata_d = d_wdata;
            be_d    = d_be;
        end else if (state_q == S_WAIT && cnt_q != CW'(1)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < DB; k++) rd_data[8*k +: 8] = mem[bidx(addr_q, k)];
        rd_if = '0;
        for (int k = 0; k < FB; k++) rd_if[8*k +: 8] = mem[bidx(addr_q, k)];
    end

`ifdef TINKER_MEM_BOUNDS_EN
    logic [ADDR_W:0] end_a;
    always_comb begin
        end_a = {1'b0, addr_q} + (chan_q ? (ADDR_W+1)'(DB) : (ADDR_W+1)'(FB));
        oob   = end_a > (ADDR_W+1)'(MEM_BYTES);
    end
`else
    logic unused_addr;
    assign unused_addr = ^addr_q[ADDR_W-1:MA];
    assign oob = 1'b0;
`endif

    // rdata shows the fresh value during RESP and holds it afterwards.
    always_comb begin
        resp         = state_q == S_RESP;
        if_ready     = gnt_f;
        d_ready      = gnt_d;
        busy         = state_q != S_IDLE;
        if_rsp_valid = resp && chan_q == CH_F;
        d_rsp_valid  = resp && chan_q == CH_D;
        err          = resp && oob;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if (if_rsp_valid) if_rdata_d = oob ? '0 : rd_if;
        if (d_rsp_valid && !we_q) d_rdata_d = oob ? '0 : rd_data;
        if_rdata     = if_rdata_d;
        d_rdata      = d_rdata_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rr_q       <= CH_F;
            chan_q     <= CH_F;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            chan_q     <= chan_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (d_rsp_valid && we_q && !oob) begin
            for (int k = 0; k < DB; k++)
                if (be_q[k]) mem[bidx(addr_q, k)] <= wdata_q[8*k +: 8];
        end
    end
endmodule
